// File: rtl/riscv_fetch_unit.sv
// riscv_fetch_unit: instruction fetch stage.
// Holds the PC and issues single-word reads with 1-cycle latency. Returned words
// are queued with their PC in a small circular buffer and handed to decode over
// a valid/ready handshake. A redirect flushes the buffer and drops any read in flight.
module riscv_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        fetch_en_i,
    output logic [31:0] iaddr_o,
    output logic        ird_o,
    input  logic [31:0] irdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    input  logic        inst_ready_i
);

    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   pc;
    logic [31:0]   resp_pc;
    logic          inflight;
    logic [31:0]   buf_inst [BUF_DEPTH];
    logic [31:0]   buf_pc   [BUF_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic [CW:0]   occupancy;
    logic [31:0]   redirect_target;
    logic          issue;
    logic          enq;
    logic          deq;

    // Credit check counts the read in flight; a same-cycle pop is not credited.
    assign occupancy       = {1'b0, count} + {{CW{1'b0}}, inflight};
    assign redirect_target = redirect_pc_i & 32'hFFFF_FFFC;
    assign issue           = reset_i & fetch_en_i & ~redirect_i
                             & (occupancy < (CW+1)'(BUF_DEPTH));
    // A redirect clears inflight, so a response can only be squashed in the
    // redirect cycle itself (ird_o is low then, so nothing is issued for t+1).
    assign enq             = inflight & ~redirect_i;
    assign deq             = inst_valid_o & inst_ready_i;

    assign iaddr_o      = reset_i ? pc : RESET_PC;
    assign ird_o        = issue;
    assign inst_valid_o = reset_i & (count != '0);
    assign inst_o       = buf_inst[rd_ptr];
    assign inst_pc_o    = buf_pc[rd_ptr];

    // PC, in-flight tracking and buffer pointers; reset beats redirect beats enq/deq.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            pc       <= RESET_PC;
            resp_pc  <= RESET_PC;
            inflight <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else if (redirect_i) begin
            pc       <= redirect_target;
            inflight <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            if (issue) begin
                pc      <= pc + 32'd4;
                resp_pc <= pc;
            end
            inflight <= issue;
            if (enq) wr_ptr <= wr_ptr + PW'(1);
            if (deq) rd_ptr <= rd_ptr + PW'(1);
            case ({enq, deq})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Buffer storage: data only, no reset needed.
    always_ff @(posedge clk_i) begin
        if (reset_i && enq) begin
            buf_inst[wr_ptr] <= irdata_i;
            buf_pc[wr_ptr]   <= resp_pc;
        end
    end

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Bench for riscv_fetch_unit: directed test-plan scenarios followed by random
// traffic, checked every cycle against a queue-based reference model.
module tb_riscv_fetch_unit;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam int          BUF_DEPTH = 2;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        fetch_en_i;
    logic [31:0] iaddr_o;
    logic        ird_o;
    logic [31:0] irdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_ready_i;

    riscv_fetch_unit #(.RESET_PC(RESET_PC), .BUF_DEPTH(BUF_DEPTH)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .fetch_en_i(fetch_en_i),
        .iaddr_o(iaddr_o), .ird_o(ird_o), .irdata_i(irdata_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .inst_valid_o(inst_valid_o), .inst_o(inst_o), .inst_pc_o(inst_pc_o),
        .inst_ready_i(inst_ready_i)
    );

    always #5 clk_i = ~clk_i;

    // Memory: 1-cycle latency, mem[A] = A ^ A5A5_0000; garbage when not read.
    always @(posedge clk_i)
        irdata_i <= ird_o ? (iaddr_o ^ 32'hA5A5_0000) : $urandom;

    // Reference model: every fetch issued since the last flush, in order, with
    // the cycle at which it becomes visible to decode (issue cycle + 2).
    typedef struct {
        logic [31:0] addr;
        int          rdy;
    } ent_t;

    ent_t        q[$];
    logic [31:0] mpc = RESET_PC;
    int          now = 0;
    int          tests = 0;
    int          fails = 0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s cycle %0d: got %h expected %h", tag, now, got, exp);
        end
    endtask

    task automatic step();
        logic exp_ird;
        logic exp_val;
        logic [31:0] exp_addr;
        @(negedge clk_i);
        exp_ird  = reset_i & fetch_en_i & ~redirect_i & (q.size() < BUF_DEPTH);
        exp_val  = reset_i && (q.size() > 0) && (q[0].rdy <= now);
        exp_addr = reset_i ? mpc : RESET_PC;
        chk("ird", {31'b0, ird_o}, {31'b0, exp_ird});
        chk("iaddr", iaddr_o, exp_addr);
        chk("valid", {31'b0, inst_valid_o}, {31'b0, exp_val});
        if (exp_val) begin
            chk("inst_pc", inst_pc_o, q[0].addr);
            chk("inst", inst_o, q[0].addr ^ 32'hA5A5_0000);
        end
        if (!reset_i) begin
            q.delete();
            mpc = RESET_PC;
        end else if (redirect_i) begin
            q.delete();
            mpc = redirect_pc_i & 32'hFFFF_FFFC;
        end else begin
            if (exp_val && inst_ready_i) void'(q.pop_front());
            if (exp_ird) begin
                q.push_back('{addr: mpc, rdy: now + 2});
                mpc = mpc + 32'd4;
            end
        end
        now++;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        reset_i       = 1'b0;
        fetch_en_i    = 1'b1;
        inst_ready_i  = 1'b1;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        @(posedge clk_i);
        #1;

        // reset held 4 cycles with fetch enabled
        repeat (4) step();

        // streaming
        reset_i = 1'b1;
        repeat (12) step();

        // back-pressure then release
        reset_i = 1'b0;
        step();
        reset_i = 1'b1;
        inst_ready_i = 1'b0;
        repeat (6) step();
        inst_ready_i = 1'b1;
        repeat (6) step();

        // redirect with 0x4 buffered and 0x8 in flight
        reset_i = 1'b0;
        step();
        reset_i = 1'b1;
        inst_ready_i = 1'b0;
        repeat (2) step();
        inst_ready_i = 1'b1;
        step();
        inst_ready_i = 1'b0;
        step();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0103;
        step();
        redirect_i   = 1'b0;
        inst_ready_i = 1'b1;
        repeat (8) step();

        // PC wrap
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFC;
        step();
        redirect_i = 1'b0;
        repeat (8) step();

        // reset with buffer full
        inst_ready_i = 1'b0;
        repeat (4) step();
        reset_i = 1'b0;
        repeat (2) step();
        reset_i      = 1'b1;
        inst_ready_i = 1'b1;
        repeat (8) step();

        // random traffic
        repeat (3000) begin
            fetch_en_i    = ($urandom_range(0, 3) != 0);
            inst_ready_i  = ($urandom_range(0, 2) != 0);
            redirect_i    = ($urandom_range(0, 19) == 0);
            redirect_pc_i = $urandom;
            reset_i       = ($urandom_range(0, 99) != 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
